// File: rtl/cv32e40x_clmul_unit_if.sv
// Handshake and operand bus between the EX stage and the carry-less multiply unit.
// The unit is the slave. The EX-side driver, or a testbench, is the master.
interface cv32e40x_clmul_unit_if;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  operator_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    modport slave (
        input  valid_i,
        input  operator_i,
        input  op_a_i,
        input  op_b_i,
        input  kill_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output result_o
    );

    modport master (
        output valid_i,
        output operator_i,
        output op_a_i,
        output op_b_i,
        output kill_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  result_o
    );
endinterface

// File: rtl/cv32e40x_clmul_unit.sv
// Iterative carry-less multiplier for the Zbc instructions clmul, clmulh and clmulr.
// Each CALC cycle consumes BITS_PER_CYCLE bits of operand B.
// The unit leaves CALC as soon as the remaining B bits are all zero.
module cv32e40x_clmul_unit #(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    cv32e40x_clmul_unit_if.slave         bus
);

    // Only power-of-two group sizes that divide 32 are supported.
    if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) || (BITS_PER_CYCLE == 4) ||
          (BITS_PER_CYCLE == 8) || (BITS_PER_CYCLE == 16) || (BITS_PER_CYCLE == 32))) begin : g_bad_bpc
        $error("cv32e40x_clmul_unit: illegal BITS_PER_CYCLE %0d", BITS_PER_CYCLE);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Pick the result window from the 64-bit carry-less product.
    // The reserved encoding executes as clmul.
    function automatic logic [31:0] f_result_sel(input logic [1:0] op, input logic [63:0] p);
        logic [31:0] res;
        case (op)
            2'b00:   res = p[31:0];
            2'b01:   res = p[63:32];
            2'b10:   res = p[62:31];
            2'b11:   res = p[31:0];
            default: res = p[31:0];
        endcase
        return res;
    endfunction

    state_e      r_state;
    state_e      w_state_nxt;
    logic [63:0] r_acc;
    logic [63:0] r_a_sh;
    logic [31:0] r_b_sh;
    logic [1:0]  r_op;
    logic        r_valid;
    logic [31:0] r_result;

    logic [63:0] w_acc_calc;
    logic [63:0] w_a_sh_post;
    logic [31:0] w_b_sh_post;
    logic        w_accept;
    logic        w_calc_en;
    logic        w_finish;
    logic        w_ready;

    // Partial-product step: XOR one shifted copy of A per set bit in the current B group.
    always_comb begin
        w_acc_calc = r_acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_b_sh[i]) begin
                w_acc_calc = w_acc_calc ^ (r_a_sh << i);
            end else begin
                w_acc_calc = w_acc_calc;
            end
        end
        w_a_sh_post = r_a_sh << BITS_PER_CYCLE;
        w_b_sh_post = r_b_sh >> BITS_PER_CYCLE;
    end

    // Qualify the datapath events. kill_i overrides every other input.
    always_comb begin
        w_accept  = (r_state == IDLE) && bus.valid_i && !bus.kill_i;
        w_calc_en = (r_state == CALC) && !bus.kill_i;
        w_finish  = w_calc_en && (w_b_sh_post == 32'd0);
    end

    // Hold the FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Compute the next state. A kill returns the FSM to IDLE from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.kill_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.valid_i) begin
                        w_state_nxt = CALC;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                CALC: begin
                    if (w_b_sh_post == 32'd0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = CALC;
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Decode the FSM state into outputs. ready_o depends on state alone.
    always_comb begin
        w_ready = (r_state == IDLE);
    end

    // Operand and accumulator registers: load on accept, then advance once per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= 64'd0;
            r_a_sh <= 64'd0;
            r_b_sh <= 32'd0;
            r_op   <= 2'd0;
        end else if (w_accept) begin
            r_acc  <= 64'd0;
            r_a_sh <= {32'd0, bus.op_a_i};
            r_b_sh <= bus.op_b_i;
            r_op   <= bus.operator_i;
        end else if (w_calc_en) begin
            r_acc  <= w_acc_calc;
            r_a_sh <= w_a_sh_post;
            r_b_sh <= w_b_sh_post;
            r_op   <= r_op;
        end else begin
            r_acc  <= r_acc;
            r_a_sh <= r_a_sh;
            r_b_sh <= r_b_sh;
            r_op   <= r_op;
        end
    end

    // Registered valid: high for exactly the cycles spent in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= (w_state_nxt == DONE);
        end
    end

    // Registered result: captured on the last CALC cycle, including that cycle's XOR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= 32'd0;
        end else if (w_finish) begin
            r_result <= f_result_sel(r_op, w_acc_calc);
        end else begin
            r_result <= r_result;
        end
    end

    assign bus.ready_o  = w_ready;
    assign bus.valid_o  = r_valid;
    assign bus.result_o = r_result;

endmodule
